// File: rtl/flux_capture_writer.sv
// Flux-timing capture: timestamps read-data edges and index pulses, encodes each as a
// byte and streams the bytes through a small FIFO into acquisition SRAM.
module flux_capture_writer #(
  parameter int ADDR_WIDTH      = 19,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                  CLK_MASTER,
  input  logic                  RESET_n,
  input  logic                  ACQUIRING,
  input  logic                  SAMPLE_CKE,
  input  logic                  FD_RDDATA_IN,
  input  logic                  FD_INDEX_IN,
  input  logic                  ADDR_CLR,
  input  logic                  SR_WR_ACK,
  output logic                  SR_WR_REQ,
  output logic [ADDR_WIDTH-1:0] SR_WR_ADDR,
  output logic [7:0]            SR_WR_DATA,
  output logic                  SR_R_FULL,
  output logic                  OVERRUN,
  output logic [ADDR_WIDTH:0]   BYTE_COUNT
);

  localparam int                   DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0]  CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]  BC_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE = 1;

  typedef enum logic {IDLE, REQ} state_t;

  logic       rd_p0, rd_p1, rd_p2, idx_p0, idx_p1, idx_p2;
  logic       flux_evt, idx_evt;
  logic       acq_prev;
  logic [6:0] count, count_nxt;
  logic       push_req;
  logic [7:0] push_data;
  logic [7:0] fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic       fifo_empty, fifo_full, push_ok, push_drop, pop, clr_ok;
  state_t     state;

  // Stage p0/p1: two-flop synchronisers; p2: previous value for rising-edge detect
  always_ff @(posedge CLK_MASTER or negedge RESET_n) begin
    if (!RESET_n) begin
      rd_p0 <= 1'b0; rd_p1 <= 1'b0; rd_p2 <= 1'b0;
      idx_p0 <= 1'b0; idx_p1 <= 1'b0; idx_p2 <= 1'b0;
      flux_evt <= 1'b0; idx_evt <= 1'b0;
    end else begin
      rd_p0 <= FD_RDDATA_IN; rd_p1 <= rd_p0; rd_p2 <= rd_p1;
      idx_p0 <= FD_INDEX_IN; idx_p1 <= idx_p0; idx_p2 <= idx_p1;
      flux_evt <= rd_p1 & ~rd_p2;
      idx_evt  <= idx_p1 & ~idx_p2;
    end
  end

  // Encoder: an event outranks the overflow marker and carries the unwrapped count
  always_comb begin
    push_req  = 1'b0;
    push_data = 8'h00;
    count_nxt = count;
    if (ACQUIRING && !acq_prev) begin
      count_nxt = 7'd0;
    end else if (ACQUIRING) begin
      if (flux_evt || idx_evt) begin
        push_req  = 1'b1;
        push_data = {idx_evt, count};
        if (flux_evt)        count_nxt = {6'd0, SAMPLE_CKE};
        else if (SAMPLE_CKE) count_nxt = count + 7'd1;
      end else if (SAMPLE_CKE) begin
        if (count == 7'h7F) begin
          push_req  = 1'b1;
          push_data = 8'h7F;
        end
        count_nxt = count + 7'd1;
      end
    end
  end

  always_ff @(posedge CLK_MASTER or negedge RESET_n) begin
    if (!RESET_n) begin
      acq_prev <= 1'b0;
      count    <= 7'd0;
    end else begin
      acq_prev <= ACQUIRING;
      count    <= count_nxt;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]) &&
                      (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]);
  assign push_ok    = push_req && !SR_R_FULL && !fifo_full;
  assign push_drop  = push_req && !SR_R_FULL && fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty && !SR_R_FULL;
  assign clr_ok     = ADDR_CLR && (state == IDLE) && fifo_empty;

  // Event FIFO: storage is data only, pointers and overrun flag are control
  always_ff @(posedge CLK_MASTER) begin
    if (push_ok) fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= push_data;
  end

  always_ff @(posedge CLK_MASTER or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      OVERRUN <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (clr_ok)         OVERRUN <= 1'b0;
      else if (push_drop) OVERRUN <= 1'b1;
    end
  end

  // Write FSM: one SRAM request per popped byte, address advances on ack
  always_ff @(posedge CLK_MASTER or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= IDLE;
      SR_WR_REQ  <= 1'b0;
      SR_WR_ADDR <= '0;
      SR_WR_DATA <= 8'h00;
      SR_R_FULL  <= 1'b0;
      BYTE_COUNT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_ok) begin
            SR_WR_ADDR <= '0;
            BYTE_COUNT <= '0;
            SR_R_FULL  <= 1'b0;
          end else if (pop) begin
            SR_WR_DATA <= fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
            SR_WR_REQ  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (SR_WR_ACK) begin
            SR_WR_REQ  <= 1'b0;
            SR_WR_ADDR <= SR_WR_ADDR + ADDR_ONE;
            BYTE_COUNT <= BYTE_COUNT + BC_ONE;
            if (BYTE_COUNT + BC_ONE == CAPACITY) SR_R_FULL <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flux_capture_writer.sv
// Directed bench for flux_capture_writer: encoding table plus overflow, overrun, full,
// reset-mid-write and drain sequences, using a small SRAM size so the full case is short.
module tb_flux_capture_writer;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, acq, cke, rd, ix, clr, ack, ack_en;
  logic          req, full, ovr;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic [AW:0]   bcnt;

  flux_capture_writer #(.ADDR_WIDTH(AW), .FIFO_DEPTH_LOG2(2)) dut (
    .CLK_MASTER(clk), .RESET_n(rst_n), .ACQUIRING(acq), .SAMPLE_CKE(cke),
    .FD_RDDATA_IN(rd), .FD_INDEX_IN(ix), .ADDR_CLR(clr), .SR_WR_ACK(ack),
    .SR_WR_REQ(req), .SR_WR_ADDR(addr), .SR_WR_DATA(data), .SR_R_FULL(full),
    .OVERRUN(ovr), .BYTE_COUNT(bcnt)
  );

  always #5 clk = ~clk;
  assign ack = ack_en & req;

  typedef struct {logic [AW-1:0] addr; logic [7:0] data; logic full;} wr_t;
  wr_t  wq[$];
  logic full_after[$];
  logic hs_prev = 1'b0;

  // Record every completed handshake and the full flag one cycle after it
  always @(negedge clk) begin
    wr_t w;
    if (hs_prev) full_after.push_back(full);
    hs_prev = req && ack;
    if (req && ack) begin
      w.addr = addr; w.data = data; w.full = full;
      wq.push_back(w);
    end
  end

  int checks = 0, errors = 0, rd_idx = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample_ticks(int n);
    if (n > 0) begin
      cke = 1'b1;
      repeat (n) tick();
      cke = 1'b0;
    end
  endtask

  task automatic edge_pins(bit f, bit x);
    rd = f; ix = x;
    repeat (5) tick();
    rd = 1'b0; ix = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_writes(int n, int budget);
    int k = 0;
    while (wq.size() < n && k < budget) begin tick(); k++; end
    if (wq.size() < n) check("write_timeout", wq.size(), n);
  endtask

  task automatic expect_write(string name, logic [AW-1:0] ea, logic [7:0] ed);
    wait_writes(rd_idx + 1, 40);
    if (rd_idx < wq.size()) begin
      check({name, "_addr"}, wq[rd_idx].addr, ea);
      check({name, "_data"}, wq[rd_idx].data, ed);
    end
    rd_idx++;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(); clr = 1'b0; tick();
  endtask

  typedef struct {bit flux; bit idx; int n; logic [7:0] exp;} vec_t;
  vec_t vecs[8];

  initial begin
    // {flux, index, sample ticks before the edge, expected byte}
    vecs[0] = '{1'b1, 1'b0, 10,  8'h0A};
    vecs[1] = '{1'b0, 1'b1, 20,  8'h94};
    vecs[2] = '{1'b1, 1'b0, 3,   8'h17};
    vecs[3] = '{1'b1, 1'b1, 5,   8'h85};
    vecs[4] = '{1'b1, 1'b0, 0,   8'h00};
    vecs[5] = '{1'b0, 1'b1, 127, 8'hFF};
    vecs[6] = '{1'b1, 1'b0, 0,   8'h7F};
    vecs[7] = '{1'b1, 1'b0, 1,   8'h01};

    rst_n = 1'b0; acq = 1'b0; cke = 1'b0; rd = 1'b0; ix = 1'b0; clr = 1'b0; ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req", req, 0);  check("rst_addr", addr, 0); check("rst_data", data, 0);
    check("rst_full", full, 0); check("rst_ovr", ovr, 0); check("rst_bcnt", bcnt, 0);
    rst_n = 1'b1;
    tick();
    acq = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      sample_ticks(vecs[i].n);
      edge_pins(vecs[i].flux, vecs[i].idx);
      expect_write($sformatf("vec%0d", i), AW'(i), vecs[i].exp);
    end
    check("table_bcnt", bcnt, 8);
    check("table_addr", addr, 8);

    // Overflow markers every 128 ticks, then the residual count
    pulse_clr();
    check("clr_bcnt", bcnt, 0);
    check("clr_addr", addr, 0);
    sample_ticks(300);
    edge_pins(1'b1, 1'b0);
    expect_write("ovf0", 0, 8'h7F);
    expect_write("ovf1", 1, 8'h7F);
    expect_write("ovf2", 2, 8'h2C);

    // Overrun: one write pending, four queued, sixth dropped
    ack_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) check("ovr_before", ovr, 0);
      sample_ticks(k);
      edge_pins(1'b1, 1'b0);
    end
    check("ovr_flag", ovr, 1);
    check("ovr_req", req, 1);
    check("ovr_data", data, 1);
    check("ovr_addr", addr, 3);
    ack_en = 1'b1;
    for (int k = 1; k <= 5; k++) expect_write($sformatf("ovr%0d", k), AW'(2 + k), 8'(k));
    repeat (10) tick();
    check("ovr_extra", wq.size(), rd_idx);
    check("ovr_bcnt", bcnt, 8);

    // Full: 16 writes, then nothing more until cleared
    pulse_clr();
    check("clr_ovr", ovr, 0);
    check("clr2_bcnt", bcnt, 0);
    for (int i = 0; i < 20; i++) begin
      sample_ticks(i % 3 + 1);
      edge_pins(1'b1, 1'b0);
      if (i < 16) expect_write($sformatf("full%0d", i), AW'(i), 8'(i % 3 + 1));
      if (i == 15) begin
        check("full_at_ack", wq[rd_idx-1].full, 0);
        check("full_after_ack", (full_after.size() >= rd_idx) ? full_after[rd_idx-1] : 1'bx, 1);
      end
    end
    check("full_nomore", wq.size(), rd_idx);
    check("full_flag", full, 1);
    check("full_bcnt", bcnt, 16);
    check("full_req", req, 0);
    check("full_addr", addr, 0);
    check("full_ovr", ovr, 0);
    pulse_clr();
    check("fclr_full", full, 0);
    check("fclr_bcnt", bcnt, 0);
    sample_ticks(2);
    edge_pins(1'b1, 1'b0);
    expect_write("fclr_wr", 0, 8'h02);

    // Asynchronous reset while a write is pending
    ack_en = 1'b0;
    sample_ticks(1);
    rd = 1'b1;
    repeat (5) tick();
    check("mid_req", req, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", req, 0);  check("arst_addr", addr, 0); check("arst_data", data, 0);
    check("arst_full", full, 0); check("arst_ovr", ovr, 0); check("arst_bcnt", bcnt, 0);
    rd = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (3) tick();
    sample_ticks(2);
    edge_pins(1'b1, 1'b0);
    expect_write("rst_after", 0, 8'h02);

    // Drain: queued bytes still written after ACQUIRING falls, new edges ignored
    ack_en = 1'b0;
    sample_ticks(3);
    edge_pins(1'b1, 1'b0);
    sample_ticks(4);
    edge_pins(1'b1, 1'b0);
    acq = 1'b0;
    edge_pins(1'b1, 1'b0);
    ack_en = 1'b1;
    expect_write("drain0", 1, 8'h03);
    expect_write("drain1", 2, 8'h04);
    repeat (10) tick();
    check("drain_extra", wq.size(), rd_idx);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
